// File: rtl/stack_mc_controller.sv
// stack_mc_controller: multicycle control unit for the stack-machine CPU.
// Sequences fetch/decode/stack/memory/ALU/branch micro-steps from the IR opcode,
// honours memory wait states and flags the last cycle of every instruction.
// Build option: define STACK_GUARD_EN to enable the stack depth guard, the
// sp_cnt occupancy counter and the terminal FAULT trap.
module stack_mc_controller #(
  parameter  int unsigned OPW   = 3,
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned ALUW  = 2,
  localparam int unsigned SPW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic            mem_ready,
  output logic            ldA,
  output logic            ldB,
  output logic            push,
  output logic            pop,
  output logic            tos,
  output logic            IRWrite,
  output logic            memWrite,
  output logic            memRead,
  output logic            pcWriteCond,
  output logic            pcWrite,
  output logic            pcSrc,
  output logic            IorD,
  output logic            srcA,
  output logic            srcB,
  output logic            MtoS,
  output logic [ALUW-1:0] ALUOp,
  output logic [SPW-1:0]  sp_cnt,
  output logic            fault,
  output logic            instr_done
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_JZ,
    S_JMP,
    S_PUSH_RD,
    S_PUSH_WR,
    S_POP1,
    S_LDA,
    S_POP_WR,
    S_POP2,
    S_LDB,
    S_ALU,
    S_NOT_ALU,
    S_PUSH_RES
`ifdef STACK_GUARD_EN
    , S_FAULT
`endif
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_NOT  = 3'd3;
  localparam logic [2:0] OP_PUSH = 3'd4;
  localparam logic [2:0] OP_POP  = 3'd5;
  localparam logic [2:0] OP_JMP  = 3'd6;
  localparam logic [2:0] OP_JZ   = 3'd7;

  state_t     r_state;
  state_t     w_dec_next;
  logic [2:0] w_op;
  logic       w_op_legal;

  // Low three bits select the instruction; any set upper bit makes it illegal.
  assign w_op       = opcode[2:0];
  assign w_op_legal = ((opcode >> 3) == '0);

`ifdef STACK_GUARD_EN
  logic [SPW-1:0] r_sp;
  logic           r_fault;
  logic           w_depth_ok;

  assign sp_cnt = r_sp;
  assign fault  = r_fault;

  // Occupancy each instruction needs before it may start.
  always_comb begin
    w_depth_ok = 1'b1;
    case (w_op)
      OP_PUSH:             w_depth_ok = (32'(r_sp) < DEPTH);
      OP_JMP:              w_depth_ok = 1'b1;
      OP_NOT, OP_POP, OP_JZ: w_depth_ok = (r_sp != '0);
      default:             w_depth_ok = (32'(r_sp) >= 32'd2);
    endcase
  end
`else
  assign sp_cnt = '0;
  assign fault  = 1'b0;
`endif

  // DECODE dispatch target, including the illegal/guard escape.
  always_comb begin
    w_dec_next = S_POP1;
    case (w_op)
      OP_JZ:   w_dec_next = S_JZ;
      OP_JMP:  w_dec_next = S_JMP;
      OP_PUSH: w_dec_next = S_PUSH_RD;
      default: w_dec_next = S_POP1;
    endcase
`ifdef STACK_GUARD_EN
    if (!w_op_legal || !w_depth_ok) w_dec_next = S_FAULT;
`else
    if (!w_op_legal) w_dec_next = S_FETCH;
`endif
  end

  // State register with next-state sequencing, stack occupancy and fault flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
`ifdef STACK_GUARD_EN
      r_sp    <= '0;
      r_fault <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE:   r_state <= w_dec_next;
        S_JZ:       r_state <= S_FETCH;
        S_JMP:      r_state <= S_FETCH;
        S_PUSH_RD:  if (mem_ready) r_state <= S_PUSH_WR;
        S_PUSH_WR:  r_state <= S_FETCH;
        S_POP1:     r_state <= S_LDA;
        S_LDA: begin
          if (w_op == OP_POP)      r_state <= S_POP_WR;
          else if (w_op == OP_NOT) r_state <= S_NOT_ALU;
          else                     r_state <= S_POP2;
        end
        S_POP_WR:   if (mem_ready) r_state <= S_FETCH;
        S_POP2:     r_state <= S_LDB;
        S_LDB:      r_state <= S_ALU;
        S_ALU:      r_state <= S_PUSH_RES;
        S_NOT_ALU:  r_state <= S_PUSH_RES;
        S_PUSH_RES: r_state <= S_FETCH;
`ifdef STACK_GUARD_EN
        S_FAULT:    r_state <= S_FAULT;
`endif
        default:    r_state <= S_FETCH;
      endcase
`ifdef STACK_GUARD_EN
      case (r_state)
        S_PUSH_WR, S_PUSH_RES: r_sp <= r_sp + SPW'(1);
        S_POP1, S_POP2:        r_sp <= r_sp - SPW'(1);
        default:               r_sp <= r_sp;
      endcase
      if (r_state == S_DECODE && w_dec_next == S_FAULT) r_fault <= 1'b1;
`endif
    end
  end

  // Moore strobe decode; handshake strobes qualified by mem_ready; all low in reset.
  always_comb begin
    ldA         = 1'b0;
    ldB         = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    tos         = 1'b0;
    IRWrite     = 1'b0;
    memWrite    = 1'b0;
    memRead     = 1'b0;
    pcWriteCond = 1'b0;
    pcWrite     = 1'b0;
    pcSrc       = 1'b0;
    IorD        = 1'b0;
    srcA        = 1'b0;
    srcB        = 1'b0;
    MtoS        = 1'b0;
    ALUOp       = '0;
    instr_done  = 1'b0;
    if (rst) begin
      tos = 1'b1;
      case (r_state)
        S_FETCH: begin
          memRead = 1'b1;
          srcA    = 1'b1;
          srcB    = 1'b1;
          tos     = 1'b0;
          IRWrite = mem_ready;
          pcWrite = mem_ready;
        end
        S_DECODE: begin
`ifndef STACK_GUARD_EN
          instr_done = !w_op_legal;
`endif
        end
        S_JZ: begin
          pcWriteCond = 1'b1;
          pcSrc       = 1'b1;
          instr_done  = 1'b1;
        end
        S_JMP: begin
          pcWrite    = 1'b1;
          pcSrc      = 1'b1;
          instr_done = 1'b1;
        end
        S_PUSH_RD: begin
          memRead = 1'b1;
          IorD    = 1'b1;
        end
        S_PUSH_WR: begin
          push       = 1'b1;
          MtoS       = 1'b1;
          instr_done = 1'b1;
        end
        S_POP1:  pop = 1'b1;
        S_LDA:   ldA = 1'b1;
        S_POP_WR: begin
          memWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_POP2:    pop   = 1'b1;
        S_LDB:     ldB   = 1'b1;
        S_ALU:     ALUOp = opcode[ALUW-1:0];
        S_NOT_ALU: ALUOp = '1;
        S_PUSH_RES: begin
          push       = 1'b1;
          instr_done = 1'b1;
        end
`ifdef STACK_GUARD_EN
        S_FAULT:   tos = 1'b0;
`endif
        default:   tos = 1'b1;
      endcase
    end
  end

endmodule
